// File: rtl/lut_ram_mp_pkg.sv
// rtl/lut_ram_mp_pkg.sv - shared types and helpers for the multi-read-port LUT RAM
// Contents:
//   lut_ram_mp_state_t  clear-sequencer states
//   addr_w()            address width for a given depth
//   be_merge()          byte-enable merge of a new word into an old word
package lut_ram_mp_pkg;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} lut_ram_mp_state_t;

  // be_merge works on a fixed maximum width; callers size in and out with casts.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lut_ram_mp_intf.sv
// rtl/lut_ram_mp_intf.sv - signal bundle matching the lut_ram_mp port list
// Ports: clk (in) shared clock; all other signals are bundle members.
interface lut_ram_mp_intf #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 64,
  parameter int NUM_RD_PORTS = 2
) (
  input logic clk
);
  localparam int ADDR_W = lut_ram_mp_pkg::addr_w(DEPTH);
  localparam int BE_W   = DATA_WIDTH / 8;

  logic                                   rst;
  logic                                   clr;
  logic                                   busy;
  logic                                   wr_en;
  logic [ADDR_W-1:0]                      wr_addr;
  logic [DATA_WIDTH-1:0]                  wr_data;
  logic [BE_W-1:0]                        wr_be;
  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_addr;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
endinterface

// File: rtl/lut_ram_clr_seq.sv
// rtl/lut_ram_clr_seq.sv - clear sweep sequencer for lut_ram_mp
// Ports:
//   clk, rst   clock, synchronous active-high reset (starts a sweep)
//   clr        sweep request, honoured only when idle
//   busy       high for the whole sweep
//   clr_we     write strobe for the sweep
//   clr_addr   word being cleared this cycle
module lut_ram_clr_seq import lut_ram_mp_pkg::*; #(
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  lut_ram_mp_state_t state;
  lut_ram_mp_state_t state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  // Counter rests at 0 in IDLE so a new sweep always starts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + ADDR_W'(1);
      else                                   clr_cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
      IDLE:    if (clr)             state_nxt = CLEAR;
      default:                      state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR);
    clr_addr = clr_cnt;
  end

endmodule

// File: rtl/lut_ram_mp.sv
// rtl/lut_ram_mp.sv - multi-read-port LUT RAM with byte enables and clear sweep
// Ports:
//   clk, rst   clock, synchronous active-high reset (triggers a clear sweep)
//   clr        clear sweep request (idle only); busy high during the sweep
//   wr_en, wr_addr, wr_data, wr_be   byte-enabled write port
//   rd_addr[p], rd_data[p]           independent read ports
module lut_ram_mp import lut_ram_mp_pkg::*; #(
  parameter  int                    DATA_WIDTH   = 32,
  parameter  int                    DEPTH        = 64,
  parameter  int                    NUM_RD_PORTS = 2,
  parameter  int                    RD_LATENCY   = 0,
  parameter  int                    BYPASS       = 1,
  parameter  logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  localparam int                    ADDR_W       = addr_w(DEPTH),
  localparam int                    BE_W         = DATA_WIDTH / 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  output logic                                   busy,
  input  logic                                   wr_en,
  input  logic [ADDR_W-1:0]                      wr_addr,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  input  logic [BE_W-1:0]                        wr_be,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data
);

  if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
    $error("lut_ram_mp: RD_LATENCY must be 0 or 1");
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("lut_ram_mp: DATA_WIDTH must be a multiple of 8 and fit be_merge");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("lut_ram_mp: DEPTH must be at least 2");
  end
  if (NUM_RD_PORTS < 1) begin : g_bad_ports
    $error("lut_ram_mp: NUM_RD_PORTS must be at least 1");
  end

  // Extra top bit so DEPTH itself is representable for range checks.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    return DATA_WIDTH'(be_merge(MAX_DATA_W'(old_word), MAX_DATA_W'(new_word), MAX_BE_W'(be)));
  endfunction

  logic                  clr_we;
  logic [ADDR_W-1:0]     clr_addr;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_word;
  logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_next;

  lut_ram_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_commit = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);

  // The sweep owns the array while busy; user writes cannot commit then.
  always_ff @(posedge clk) begin
    if (clr_we)         mem[clr_addr] <= INIT_VALUE;
    else if (wr_commit) mem[wr_addr]  <= merge_word(mem[wr_addr], wr_data, wr_be);
  end

  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_word[p] = '0;
      if ({1'b0, rd_addr[p]} < DEPTH_W) rd_word[p] = mem[rd_addr[p]];
    end
  end

  // Bypass only matters for the registered read; the combinational read is
  // read-before-write by construction.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (busy)
        rd_next[p] = INIT_VALUE;
      else if (BYPASS != 0 && RD_LATENCY == 1 && wr_commit && wr_addr == rd_addr[p])
        rd_next[p] = merge_word(rd_word[p], wr_data, wr_be);
      else
        rd_next[p] = rd_word[p];
    end
  end

  if (RD_LATENCY == 0) begin : g_comb_rd
    assign rd_data = rd_next;
  end else begin : g_reg_rd
    always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_lut_ram_mp.sv
// tb/tb_lut_ram_mp.sv - scoreboard bench for lut_ram_mp
module tb_lut_ram_mp;

  localparam int          D0    = 64;
  localparam int          D1    = 48;
  localparam logic [31:0] INIT1 = 32'h0BAD_F00D;

  typedef struct {
    int          due;
    int          src;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  logic             busy1, busy2;
  logic [1:0][31:0] rd1, rd2;

  logic [31:0] m0 [D0];
  logic [31:0] m1 [D1];
  int          left0, left1;
  bit          started;

  lut_ram_mp_intf #(.DATA_WIDTH(32), .DEPTH(D0), .NUM_RD_PORTS(2)) bus (.clk(clk));

  lut_ram_mp #(.DATA_WIDTH(32), .DEPTH(D0), .NUM_RD_PORTS(2), .RD_LATENCY(0),
               .BYPASS(1), .INIT_VALUE(32'h0)) dut0 (
    .clk(clk), .rst(bus.rst), .clr(bus.clr), .busy(bus.busy),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .wr_be(bus.wr_be),
    .rd_addr(bus.rd_addr), .rd_data(bus.rd_data));

  lut_ram_mp #(.DATA_WIDTH(32), .DEPTH(D1), .NUM_RD_PORTS(2), .RD_LATENCY(1),
               .BYPASS(1), .INIT_VALUE(INIT1)) dut1 (
    .clk(clk), .rst(bus.rst), .clr(bus.clr), .busy(busy1),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .wr_be(bus.wr_be),
    .rd_addr(bus.rd_addr), .rd_data(rd1));

  lut_ram_mp #(.DATA_WIDTH(32), .DEPTH(D1), .NUM_RD_PORTS(2), .RD_LATENCY(1),
               .BYPASS(0), .INIT_VALUE(INIT1)) dut2 (
    .clk(clk), .rst(bus.rst), .clr(bus.clr), .busy(busy2),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data), .wr_be(bus.wr_be),
    .rd_addr(bus.rd_addr), .rd_data(rd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic void push(input int due, input int src, input logic [31:0] exp);
    exp_t e;
    e.due = due;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  function automatic string src_name(input int src);
    case (src)
      0: return "dut0_rd0";
      1: return "dut0_rd1";
      2: return "dut1_rd0";
      3: return "dut1_rd1";
      4: return "dut2_rd0";
      5: return "dut2_rd1";
      6: return "dut0_busy";
      7: return "dut1_busy";
      default: return "dut2_busy";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int src);
    case (src)
      0: return bus.rd_data[0];
      1: return bus.rd_data[1];
      2: return rd1[0];
      3: return rd1[1];
      4: return rd2[0];
      5: return rd2[1];
      6: return {31'b0, bus.busy};
      7: return {31'b0, busy1};
      default: return {31'b0, busy2};
    endcase
  endfunction

  always @(negedge clk) begin
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        act = actual(sb[i].src);
        checks++;
        if (sb[i].due != cyc || act !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cycle=%0d actual=%h expected=%h", src_name(sb[i].src), cyc,
                   act, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Drive one cycle of stimulus, queue what every output must show, then
  // advance the reference model to the state after the coming edge.
  task automatic step(input logic r, input logic c, input logic we, input int wa,
                      input logic [31:0] wd, input logic [3:0] be, input int ra0, input int ra1);
    int          ra [2];
    logic [31:0] old1, byp;
    @(posedge clk);
    #1;
    bus.rst        = r;
    bus.clr        = c;
    bus.wr_en      = we;
    bus.wr_addr    = 6'(wa);
    bus.wr_data    = wd;
    bus.wr_be      = be;
    bus.rd_addr[0] = 6'(ra0);
    bus.rd_addr[1] = 6'(ra1);
    ra[0] = ra0;
    ra[1] = ra1;
    if (started) begin
      push(cyc, 6, {31'b0, left0 > 0});
      push(cyc, 7, {31'b0, left1 > 0});
      push(cyc, 8, {31'b0, left1 > 0});
      for (int p = 0; p < 2; p++) begin
        push(cyc, p, (left0 > 0) ? 32'h0 : ((ra[p] < D0) ? m0[ra[p]] : 32'h0));
        old1 = (left1 > 0) ? INIT1 : ((ra[p] < D1) ? m1[ra[p]] : 32'h0);
        byp  = old1;
        if (left1 == 0 && we && wa < D1 && wa == ra[p]) byp = ref_merge(old1, wd, be);
        push(cyc + 1, 2 + p, r ? 32'h0 : byp);
        push(cyc + 1, 4 + p, r ? 32'h0 : old1);
      end
    end
    if (r) begin
      started = 1'b1;
      left0 = D0;
      left1 = D1;
      foreach (m0[k]) m0[k] = 32'h0;
      foreach (m1[k]) m1[k] = INIT1;
    end else begin
      if (left0 > 0) left0--;
      else begin
        if (we && wa < D0) m0[wa] = ref_merge(m0[wa], wd, be);
        if (c) begin
          left0 = D0;
          foreach (m0[k]) m0[k] = 32'h0;
        end
      end
      if (left1 > 0) left1--;
      else begin
        if (we && wa < D1) m1[wa] = ref_merge(m1[wa], wd, be);
        if (c) begin
          left1 = D1;
          foreach (m1[k]) m1[k] = INIT1;
        end
      end
    end
  endtask

  task automatic idle_rnd(input int n, input bit writes);
    for (int k = 0; k < n; k++)
      step(1'b0, 1'b0, writes ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 63),
           $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 63), $urandom_range(0, 63));
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, a, 63 - a);
  endtask

  initial begin
    int a;
    checks   = 0;
    failures = 0;
    started  = 1'b0;
    bus.rst = 1'b1; bus.clr = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.wr_be = '0; bus.rd_addr = '0;

    step(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0, 0, 0);
    idle_rnd(66, 1'b1);
    read_all();

    step(1'b0, 1'b0, 1'b1, 5, 32'hAABBCCDD, 4'hF, 5, 5);
    step(1'b0, 1'b0, 1'b1, 5, 32'h11223344, 4'h5, 5, 5);
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 5, 5);
    push(cyc, 0, 32'hAA22CC44);

    step(1'b0, 1'b0, 1'b1, 3, 32'hDEADBEEF, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b1, 7, 32'h12345678, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 3, 7);
    push(cyc, 0, 32'hDEADBEEF);
    push(cyc, 1, 32'h12345678);
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 3, 3);
    push(cyc, 0, 32'hDEADBEEF);
    push(cyc, 1, 32'hDEADBEEF);

    step(1'b0, 1'b0, 1'b1, 9, 32'h0, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b1, 9, 32'hCAFEF00D, 4'h3, 9, 0);
    push(cyc + 1, 2, 32'h0000F00D);
    push(cyc + 1, 4, 32'h00000000);

    step(1'b0, 1'b0, 1'b1, 2, 32'h22222222, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b1, 50, 32'hFFFFFFFF, 4'hF, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, 2, 50);
    push(cyc + 1, 2, 32'h22222222);
    push(cyc + 1, 3, 32'h00000000);

    for (a = 0; a < 64; a++) step(1'b0, 1'b0, 1'b1, a, 32'(a + 1), 4'hF, a, 0);
    step(1'b0, 1'b1, 1'b0, 0, 32'h0, 4'h0, 1, 2);
    idle_rnd(10, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 32'h0, 4'h0, 1, 2);
    idle_rnd(56, 1'b1);
    read_all();

    for (a = 0; a < 64; a++) step(1'b0, 1'b0, 1'b1, a, 32'(a + 1), 4'hF, a, 63 - a);
    step(1'b0, 1'b1, 1'b0, 0, 32'h0, 4'h0, 0, 0);
    idle_rnd(29, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4, 32'h5, 4'hF, 4, 4);
    idle_rnd(66, 1'b1);
    read_all();

    for (int k = 0; k < 600; k++) begin
      a = $urandom_range(0, 63);
      step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 9) < 7), a, $urandom, 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 63), $urandom_range(0, 63));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending expected=0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_ram_mp.md
Name: lut_ram_mp

Overview:
Parametrised multi-read-port LUT RAM; successor to the single-port lut_ram used for small scratch/tables in the riscv_32i datapath. Adds N independent read ports, byte-enable writes, optional registered read with write-bypass, and a hardware clear sequencer that sweeps the array to INIT_VALUE after reset or on request. Target: distributed RAM. Clients: register-file-like tables, branch/tag LUTs.

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of 8.
DEPTH, 64, number of words; need not be a power of two; must be >= 2.
NUM_RD_PORTS, 2, independent read ports; must be >= 1.
RD_LATENCY, 0, 0 = combinational read, 1 = registered read; other values illegal (elaboration $error).
BYPASS, 1, with RD_LATENCY=1 only: a same-cycle write to the read address is forwarded.
INIT_VALUE, '0, value written by the clear sweep.

Ports:
clk  in  1  clock, all state on posedge.
rst  in  1  synchronous, active-high reset.
clr  in  1  request clear sweep; sampled only in IDLE.
busy  out  1  high while the clear sweep runs.
wr_en  in  1  write strobe.
wr_addr  in  ADDR_W  write address; ADDR_W = $clog2(DEPTH).
wr_data  in  DATA_WIDTH  write data.
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
rd_addr  in  [NUM_RD_PORTS][ADDR_W]  read addresses.
rd_data  out  [NUM_RD_PORTS][DATA_WIDTH]  read data.

Behaviour:
- FSM states: CLEAR, IDLE. rst=1 -> state CLEAR, clr_cnt=0, busy=1, rd_data registers (RD_LATENCY=1)=0.
- CLEAR: each cycle mem[clr_cnt] <= INIT_VALUE, clr_cnt++. On the cycle clr_cnt==DEPTH-1, write the last word and go to IDLE next cycle. Sweep = exactly DEPTH cycles with busy=1, counted from the first cycle after rst deasserts.
- IDLE: busy=0. clr=1 -> CLEAR next cycle, clr_cnt=0; a write in that same cycle still commits, then the sweep clears it.
- clr while busy: ignored; the sweep does not restart.
- rst mid-sweep: sweep restarts from address 0.
- Write in IDLE: on posedge with wr_en=1, bytes with wr_be[i]=1 update; other bytes hold. wr_be=0 means no change.
- Write while busy: dropped.
- Address wr_addr >= DEPTH: write dropped.
- Read, RD_LATENCY=0: rd_data[p]=mem[rd_addr[p]] combinationally. A write shows on the read port in the cycle after its posedge (read-before-write).
- Read, RD_LATENCY=1: rd_data[p] registered, one cycle latency.
  - BYPASS=1: same-cycle wr_addr==rd_addr[p] with the write committing -> registered value is old word merged with enabled new bytes.
  - BYPASS=0: old word.
- rd_addr[p] >= DEPTH: returns 0.
- While busy: all rd_data = INIT_VALUE. For RD_LATENCY=1 this applies to the registered value.
- Ports are independent; identical addresses on several ports are legal and return the same data.

Decomposition:
- Package lut_ram_mp_pkg holds:
  - typedef enum {CLEAR, IDLE} lut_ram_mp_state_t;
  - function be_merge(old, new, be);
  - ADDR_W helper.
- be_merge is reused by the bypass path and the write path.
- One sub-module, lut_ram_clr_seq: FSM plus clr_cnt; outputs busy, clr_we, clr_addr.
- Interface lut_ram_mp_intf, parametrised like the DUT, for the bench.

Test Plan:
1. Reset sweep (DEPTH=64, INIT_VALUE=0): rst high 2 cycles, then low -> busy=1 for exactly 64 cycles; afterwards read of every address = 0.
2. Byte enables: write 0xAABBCCDD to addr 5 with be=4'b1111, then 0x11223344 with be=4'b0101 -> port0 reads 0xAA22CC44.
3. Multi-port, RD_LATENCY=0: write 0xDEADBEEF to addr 3 and 0x12345678 to addr 7; set rd_addr = {3, 7} -> rd_data = {0xDEADBEEF, 0x12345678} in the same cycle; rd_addr = {3, 3} -> both ports 0xDEADBEEF.
4. Bypass, RD_LATENCY=1: addr 9 holds 0x0; same cycle wr addr 9 data 0xCAFEF00D be=4'b0011 with rd_addr[0]=9 -> next cycle rd_data[0]=0x0000F00D (BYPASS=1) or 0x00000000 (BYPASS=0).
5. Clear, busy writes, mid-sweep reset:
   - After filling addr 0..63 with i+1, pulse clr -> busy 64 cycles.
   - Writes during the sweep are dropped; rd_data reads INIT_VALUE throughout.
   - All entries read 0 afterwards.
   - Assert rst at sweep cycle 30 -> sweep restarts; busy lasts 64 cycles after rst falls.
6. Non-power-of-two DEPTH=48: write addr 50 is dropped (no alias to addr 2, which keeps its value); read addr 50 returns 0.
